// File: rtl/sram_arbiter.sv
// Three-port arbiter for a single-port SRAM macro: management (wb) port plus
// core data (dm) and instruction (im) ports, with a bounded wb burst.
module sram_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int WB_BURST_MAX = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              core_en,
  input  logic              wb_req,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_wdata,
  input  logic [3:0]        wb_wmask,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_wmask,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic              wb_gnt,
  output logic              dm_gnt,
  output logic              im_gnt,
  output logic              wb_rvalid,
  output logic              dm_rvalid,
  output logic              im_rvalid,
  output logic [31:0]       rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic [3:0]        sram_wmask,
  input  logic [31:0]       sram_dout
);

  localparam int SW = $clog2(WB_BURST_MAX + 1);

  logic [SW-1:0]     streak_q, streak_d;
  logic              ptr_q, ptr_d;     // 1: dm served last, so im wins the next tie
  logic [2:0]        pend_q, pend_d;   // read owner {wb, dm, im} of the access in flight
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [3:0]        wmask_q;

  logic dm_eff, im_eff, core_any, reserved, core_dm, core_im;

  always_comb begin
    dm_eff   = dm_req & core_en;
    im_eff   = im_req & core_en;
    core_any = dm_eff | im_eff;
    reserved = (streak_q == SW'(WB_BURST_MAX));
    core_dm  = dm_eff & (~im_eff | ~ptr_q);
    core_im  = im_eff & ~core_dm;

    wb_gnt = 1'b0;
    dm_gnt = 1'b0;
    im_gnt = 1'b0;
    if (!wb_rst_i) begin
      if (wb_req && !(reserved && core_any)) begin
        wb_gnt = 1'b1;
      end else begin
        dm_gnt = core_dm;
        im_gnt = core_im;
      end
    end

    ptr_d = ptr_q;
    if (dm_gnt)      ptr_d = 1'b1;
    else if (im_gnt) ptr_d = 1'b0;

    streak_d = streak_q;
    if (dm_gnt || im_gnt || !core_any) streak_d = '0;
    else if (wb_gnt)                   streak_d = streak_q + SW'(1);

    pend_d = {wb_gnt & ~wb_we, dm_gnt & ~dm_we, im_gnt};

    // Idle cycles keep the previous address/data on the macro pins.
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = addr_q;
    sram_din   = din_q;
    sram_wmask = wmask_q;
    if (wb_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~wb_we;
      sram_addr  = wb_addr;
      sram_din   = wb_wdata;
      sram_wmask = wb_wmask;
    end else if (dm_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~dm_we;
      sram_addr  = dm_addr;
      sram_din   = dm_wdata;
      sram_wmask = dm_wmask;
    end else if (im_gnt) begin
      sram_csb  = 1'b0;
      sram_addr = im_addr;
    end
    if (wb_rst_i) begin
      sram_addr  = '0;
      sram_din   = '0;
      sram_wmask = '0;
    end

    {wb_rvalid, dm_rvalid, im_rvalid} = pend_q & {3{~wb_rst_i}};
    rdata = (wb_rvalid | dm_rvalid | im_rvalid) ? sram_dout : 32'h0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      streak_q <= '0;
      ptr_q    <= 1'b0;
      pend_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      wmask_q  <= '0;
    end else begin
      streak_q <= streak_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      addr_q   <= sram_addr;
      din_q    <= sram_din;
      wmask_q  <= sram_wmask;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a transaction-level arbitration model
// predicts grants, pin values and read data; a negedge monitor compares.
module tb_sram_arbiter;

  localparam int AW  = 9;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_en = 1'b1;
  logic          wb_req = 0, wb_we = 0, dm_req = 0, dm_we = 0, im_req = 0;
  logic [AW-1:0] wb_addr = '0, dm_addr = '0, im_addr = '0;
  logic [31:0]   wb_wdata = '0, dm_wdata = '0;
  logic [3:0]    wb_wmask = '0, dm_wmask = '0;
  logic          wb_gnt, dm_gnt, im_gnt, wb_rvalid, dm_rvalid, im_rvalid;
  logic [31:0]   rdata, sram_din;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_wmask;
  logic [31:0]   sram_dout = '0;

  sram_arbiter #(.ADDR_W(AW), .WB_BURST_MAX(MAX)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .core_en(core_en),
    .wb_req(wb_req), .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmask(wb_wmask),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .im_req(im_req), .im_addr(im_addr),
    .wb_gnt(wb_gnt), .dm_gnt(dm_gnt), .im_gnt(im_gnt),
    .wb_rvalid(wb_rvalid), .dm_rvalid(dm_rvalid), .im_rvalid(im_rvalid), .rdata(rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_wmask(sram_wmask), .sram_dout(sram_dout));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    gnt;
    logic          csb, web;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    wmask;
  } gexp_t;
  typedef struct {
    int         due;
    logic [2:0] owner;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int tests = 0, fails = 0, cyc = 0;

  logic [31:0]   ref_mem [512];
  logic [31:0]   sram_mem[512];
  int            m_run;
  bit            m_dm_turn;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_din;
  logic [3:0]    last_wmask;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_din, sram_wmask);
      else           sram_dout <= sram_mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    gexp_t g;
    logic [2:0]  er;
    logic [31:0] ed;
    if (rst) begin
      chk("rst_gnt", {29'b0, wb_gnt, dm_gnt, im_gnt}, 32'h0);
      chk("rst_rvalid", {29'b0, wb_rvalid, dm_rvalid, im_rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_csb_web", {30'b0, sram_csb, sram_web}, 32'h3);
      chk("rst_pins", {19'b0, sram_addr, sram_wmask} | sram_din, 32'h0);
    end else begin
      if (gq.size() > 0) begin
        g = gq.pop_front();
        chk("gnt", {29'b0, wb_gnt, dm_gnt, im_gnt}, {29'b0, g.gnt});
        chk("csb_web", {30'b0, sram_csb, sram_web}, {30'b0, g.csb, g.web});
        chk("addr", {23'b0, sram_addr}, {23'b0, g.addr});
        chk("din", sram_din, g.din);
        chk("wmask", {28'b0, sram_wmask}, {28'b0, g.wmask});
      end
      er = 3'b000;
      ed = 32'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        er = rq[0].owner;
        ed = rq[0].data;
        void'(rq.pop_front());
      end
      chk("rvalid", {29'b0, wb_rvalid, dm_rvalid, im_rvalid}, {29'b0, er});
      chk("rdata", rdata, ed);
    end
  end

  task automatic do_reset(int n);
    rst = 1'b1;
    gq.delete();
    rq.delete();
    m_run = 0;
    m_dm_turn = 1'b1;
    last_addr = '0;
    last_din = '0;
    last_wmask = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One arbitration cycle; called just after a rising edge with inputs set.
  task automatic drive_cycle();
    bit    w, d, i, core;
    logic [2:0] g;
    gexp_t e;
    rexp_t r;
    w = wb_req;
    d = dm_req && core_en;
    i = im_req && core_en;
    core = d || i;
    g = 3'b000;
    if (w && (!core || m_run < MAX)) g = 3'b100;
    else if (d && (!i || m_dm_turn)) g = 3'b010;
    else if (i)                      g = 3'b001;
    m_run = (g == 3'b100 && core) ? m_run + 1 : 0;
    if (g == 3'b010) m_dm_turn = 1'b0;
    if (g == 3'b001) m_dm_turn = 1'b1;

    e.gnt = g; e.csb = (g == 3'b000); e.web = 1'b1;
    e.addr = last_addr; e.din = last_din; e.wmask = last_wmask;
    if (g == 3'b100) begin
      e.web = ~wb_we; e.addr = wb_addr; e.din = wb_wdata; e.wmask = wb_wmask;
    end else if (g == 3'b010) begin
      e.web = ~dm_we; e.addr = dm_addr; e.din = dm_wdata; e.wmask = dm_wmask;
    end else if (g == 3'b001) begin
      e.addr = im_addr;
    end
    if (g != 3'b000) begin
      if (!e.web) ref_mem[e.addr] = merge(ref_mem[e.addr], e.din, e.wmask);
      else begin
        r.due = cyc + 1; r.owner = g; r.data = ref_mem[e.addr];
        rq.push_back(r);
      end
    end
    last_addr = e.addr; last_din = e.din; last_wmask = e.wmask;
    gq.push_back(e);
    @(posedge clk);
    #1;
    if (g[2]) wb_req = 1'b0;
    if (g[1]) dm_req = 1'b0;
    if (g[0]) im_req = 1'b0;
  endtask

  task automatic idle(int n);
    wb_req = 0; dm_req = 0; im_req = 0;
    repeat (n) drive_cycle();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom % 5 == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
  endfunction

  task automatic rand_stim();
    if (!wb_req && $urandom % 3 == 0) begin
      wb_req = 1; wb_we = 1'($urandom); wb_addr = rnd_addr();
      wb_wdata = $urandom; wb_wmask = 4'($urandom);
    end
    if (!dm_req && $urandom % 2 == 0) begin
      dm_req = 1; dm_we = 1'($urandom); dm_addr = rnd_addr();
      dm_wdata = $urandom; dm_wmask = 4'($urandom);
    end else if (dm_req && $urandom % 16 == 0) begin
      dm_req = 0;
    end
    if (!im_req && $urandom % 2 == 0) begin
      im_req = 1; im_addr = rnd_addr();
    end
    core_en = ($urandom % 8) != 0;
  endtask

  initial begin
    for (int a = 0; a < 512; a++) begin
      ref_mem[a]  = 32'hA5000000 ^ (a * 32'h00010101);
      sram_mem[a] = 32'hA5000000 ^ (a * 32'h00010101);
    end
    ref_mem[9'h010]  = 32'hDEADBEEF;
    sram_mem[9'h010] = 32'hDEADBEEF;
    dm_req = 1; im_req = 1; wb_req = 1;
    do_reset(3);

    idle(1);
    im_req = 1; im_addr = 9'h010;
    drive_cycle();
    idle(2);

    for (int k = 0; k < 4; k++) begin
      dm_req = 1; dm_we = 0; dm_addr = AW'(k);
      im_req = 1; im_addr = AW'(k + 4);
      drive_cycle();
    end
    idle(1);

    wb_we = 0; dm_we = 0;
    for (int k = 0; k < 15; k++) begin
      wb_req = 1; wb_addr = AW'(k);
      dm_req = 1; dm_addr = AW'(k + 32);
      drive_cycle();
    end
    idle(1);

    wb_req = 1; wb_we = 1; wb_addr = 9'h1FF; wb_wdata = 32'h12345678; wb_wmask = 4'hF;
    drive_cycle();
    idle(1);
    wb_req = 1; wb_we = 0; wb_addr = 9'h1FF;
    drive_cycle();
    idle(2);

    core_en = 0;
    for (int k = 0; k < 6; k++) begin
      dm_req = 1; dm_we = 0; im_req = 1; wb_req = 1; wb_we = 0;
      drive_cycle();
    end
    core_en = 1; wb_req = 0;
    drive_cycle();
    idle(2);

    do_reset(1);
    dm_req = 1; dm_we = 0; dm_addr = 9'h010;
    drive_cycle();
    dm_req = 1;
    do_reset(2);
    idle(1);

    for (int k = 0; k < 3000; k++) begin
      rand_stim();
      drive_cycle();
    end
    core_en = 1;
    idle(3);
    chk("rd_q_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SRAM word-address width (512 words).
REQ-002 Parameter WB_BURST_MAX, default 4, max consecutive wishbone grants while a core port waits.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 core_en  in  1  core-port enable (driven from logic analyser); 0 masks dm_req and im_req.
REQ-006 wb_req, wb_we  in  1,1  management-port request and write strobe.
REQ-007 wb_addr, wb_wdata, wb_wmask  in  ADDR_W,32,4  management-port address, write data and byte mask.
REQ-008 dm_req, dm_we  in  1,1  core data-port request and write strobe.
REQ-009 dm_addr, dm_wdata, dm_wmask  in  ADDR_W,32,4  core data-port address, write data and byte mask.
REQ-010 im_req, im_addr  in  1,ADDR_W  core instruction-port read request (read-only).
REQ-011 wb_gnt, dm_gnt, im_gnt  out  1 each  access accepted this cycle.
REQ-012 wb_rvalid, dm_rvalid, im_rvalid  out  1 each  read data valid this cycle.
REQ-013 rdata  out  32  shared read-data bus.
REQ-014 sram_csb, sram_web  out  1,1  macro chip select and write enable, both active-low.
REQ-015 sram_addr, sram_din, sram_wmask  out  ADDR_W,32,4  macro address, write data and write mask.
REQ-016 sram_dout  in  32  macro read data, valid the cycle after a read access.

Function
REQ-017 Effective requests: wb_eff = wb_req; dm_eff = dm_req & core_en; im_eff = im_req & core_en.
REQ-018 At most one *_gnt is high per cycle; grant is combinational from the effective requests and the arbiter state.
REQ-019 Priority: wb_eff wins over the core ports, except in a reserved cycle (REQ-022).
REQ-020 Between dm and im: round-robin using a 1-bit last-served pointer; after reset dm wins the first tie.
REQ-021 The pointer updates only when dm or im is granted; a single requester is granted regardless of the pointer.
REQ-022 wb_streak counter: increments on each wb grant while dm_eff|im_eff is high; clears on any core grant or when no core port requests.
REQ-023 When wb_streak == WB_BURST_MAX, the cycle is reserved: the core round-robin winner is granted and wb_gnt is 0.
REQ-024 On a grant, the granted port's fields drive sram_* in the same cycle; sram_csb=0; sram_web=~we (im: web=1).
REQ-025 With no grant: sram_csb=1, sram_web=1; sram_addr, sram_din and sram_wmask hold their previous values.
REQ-026 Read grant at cycle N: the owning *_rvalid=1 at N+1 with rdata=sram_dout; other rvalids are 0.
REQ-027 Write grants produce no rvalid.
REQ-028 rdata is 0 whenever no rvalid is high.
REQ-029 Requesters hold req and fields stable until gnt; dropping req before gnt is legal and has no side effect.
REQ-030 Back-to-back grants are allowed every cycle, with no bubble between different owners.
REQ-031 core_en falling while a core read is in flight still delivers that read's rvalid at N+1.

Reset
REQ-032 While wb_rst_i=1: all gnt=0, all rvalid=0, rdata=0, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, sram_wmask=0.
REQ-033 Reset clears the pointer (favours dm), wb_streak and the pending-read owner.
REQ-034 A read granted in the cycle reset asserts produces no rvalid.

Verification
REQ-035 Only im_req at addr 0x010, with sram_dout=0xDEADBEEF next cycle -> im_gnt in cycle N; im_rvalid and rdata=0xDEADBEEF in cycle N+1.
REQ-036 dm_req and im_req held together for 4 cycles after reset -> grant order dm, im, dm, im.
REQ-037 wb_req and dm_req held continuously -> wb granted 4 cycles, dm granted cycle 5, then wb resumes; pattern repeats.
REQ-038 wb write to addr 0x1FF, data 0x12345678, wmask 0xF -> sram_csb=0, sram_web=0, sram_addr=0x1FF, sram_din=0x12345678 in the grant cycle; no rvalid follows.
REQ-039 core_en=0 with dm_req=im_req=1 -> no core grants, wb_streak stays 0; core_en=1 -> dm granted next cycle.
REQ-040 Reset asserted in the cycle of a dm read grant -> next cycle: dm_rvalid=0, sram_csb=1, all outputs at their REQ-032 values.
